// File: rtl/nv_ram_rwsthp_19x32_fifo_pkg.sv
// nv_ram_rwsthp_19x32_fifo_pkg: shared geometry and pointer helper for the 19x32 RAM-wrapped FIFO
package nv_ram_rwsthp_19x32_fifo_pkg;
  localparam int ram_depth = 19;
  localparam int fifo_depth = 20;
  localparam int data_w = 32;
  localparam int ptr_w = 5;
  function automatic logic [ptr_w-1:0] wrap_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(ram_depth - 1)) ? '0 : p + ptr_w'(1);
  endfunction
endpackage

// File: rtl/nv_ram_rwsthp_19x32.sv
// nv_ram_rwsthp_19x32: 19x32 RAM with registered read address, output register and bypass mux
module nv_ram_rwsthp_19x32
  import nv_ram_rwsthp_19x32_fifo_pkg::*;
(
  input  logic              clk,
  input  logic [31:0]       pwrbus_ram_pd,
  input  logic              re,
  input  logic [ptr_w-1:0]  ra,
  input  logic              we,
  input  logic [ptr_w-1:0]  wa,
  input  logic [data_w-1:0] di,
  input  logic              byp_sel,
  input  logic [data_w-1:0] dbyp,
  input  logic              ore,
  output logic [data_w-1:0] dout
);
  logic [data_w-1:0] mem [ram_depth];
  logic [ptr_w-1:0]  ra_d;
  logic              unused_pd;
  assign unused_pd = ^pwrbus_ram_pd;
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= di;
    if (re) ra_d <= ra;
    if (ore) dout <= byp_sel ? dbyp : mem[ra_d];
  end
endmodule

// File: rtl/nv_ram_rwsthp_19x32_fifo.sv
// nv_ram_rwsthp_19x32_fifo: valid/ready FIFO of depth 20 (19 RAM entries plus the RAM output register)
module nv_ram_rwsthp_19x32_fifo
  import nv_ram_rwsthp_19x32_fifo_pkg::*;
(
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              wr_pvld,
  output logic              wr_prdy,
  input  logic [data_w-1:0] wr_pd,
  output logic              rd_pvld,
  input  logic              rd_prdy,
  output logic [data_w-1:0] rd_pd,
  output logic [4:0]        fifo_count,
  output logic              idle,
  input  logic [31:0]       pwrbus_ram_pd
);
  logic [ptr_w-1:0] wr_ptr, rd_ptr, wa, ra;
  logic [4:0]       ram_used, ram_used_nxt, unissued;
  logic             s1_vld, out_vld, s1_vld_nxt, out_vld_nxt;
  logic             wr_acc, pop, out_free, s1_adv, bypass, we, re, ore, byp_sel;
  always_comb begin
    unissued     = ram_used - 5'(s1_vld);
    wr_acc       = wr_pvld & wr_prdy;
    pop          = out_vld & rd_prdy;
    out_free     = !out_vld | rd_prdy;
    s1_adv       = s1_vld & out_free;
    bypass       = wr_acc & (unissued == '0) & !s1_vld & out_free;
    we           = wr_acc & !bypass;
    re           = (unissued != '0) & (!s1_vld | s1_adv);
    ore          = s1_adv | bypass;
    byp_sel      = bypass;
    s1_vld_nxt   = re | (s1_vld & !s1_adv);
    out_vld_nxt  = s1_adv | bypass | (out_vld & !pop);
    ram_used_nxt = ram_used + 5'(we) - 5'(s1_adv);
  end
  assign wa = wr_ptr;
  assign ra = rd_ptr;
  // wr_prdy and fifo_count are registered copies of the next-state occupancy
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ram_used   <= '0;
      s1_vld     <= 1'b0;
      out_vld    <= 1'b0;
      wr_prdy    <= 1'b0;
      fifo_count <= '0;
    end else begin
      wr_ptr     <= we ? wrap_inc(wr_ptr) : wr_ptr;
      rd_ptr     <= re ? wrap_inc(rd_ptr) : rd_ptr;
      ram_used   <= ram_used_nxt;
      s1_vld     <= s1_vld_nxt;
      out_vld    <= out_vld_nxt;
      wr_prdy    <= ram_used_nxt < 5'(ram_depth);
      fifo_count <= ram_used_nxt + 5'(out_vld_nxt);
    end
  end
  assign rd_pvld = out_vld;
  assign idle    = (fifo_count == '0) && !s1_vld;
  nv_ram_rwsthp_19x32 u_ram (
    .clk           (nvdla_core_clk),
    .pwrbus_ram_pd (pwrbus_ram_pd),
    .re            (re),
    .ra            (ra),
    .we            (we),
    .wa            (wa),
    .di            (wr_pd),
    .byp_sel       (byp_sel),
    .dbyp          (wr_pd),
    .ore           (ore),
    .dout          (rd_pd)
  );
endmodule
